sram_arbiter: RTL and testbench

- Shares one external asynchronous SRAM chip between NUM_REQ requesters (0 = instruction fetch, 1 = data, 2 = DMA/loader).
- Sequences every SRAM access with a single-clock FSM, so the design needs no 2x clock.
- Arbitrates round-robin and returns read data with a one-cycle valid strobe.
- Sits between the bus slaves and the Sram_if pins, one instance per chip (base/ext).

---
 rtl/sram_pkg.sv | 42 ++++
 rtl/sram_rr_arbiter.sv | 27 ++
 rtl/sram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and the round-robin winner search for the SRAM arbiter and,
// later, the bus crossbar.
package sram_pkg;

  localparam int MAX_REQ     = 4;
  localparam int RR_IDX_W    = 2;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    TURN  = 3'd4
  } SramState_t;

  typedef logic [SRAM_ADDR_W-1:0] SramAddr_t;
  typedef logic [SRAM_DATA_W-1:0] SramData_t;

  // First requester with req set, searching upward from ptr and wrapping at n.
  function automatic logic [RR_IDX_W-1:0] rr_winner(
    input logic [MAX_REQ-1:0]  req,
    input logic [RR_IDX_W-1:0] ptr,
    input int                  n
  );
    logic [RR_IDX_W-1:0] win;
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = RR_IDX_W'((int'(ptr) + k) % n);
      if ((k < n) && !found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus priority pointer in,
// one-hot grant, grant index and valid out.
module rr_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [RR_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [RR_IDX_W-1:0] gnt_idx,
  output logic                vld
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    vld                  = |req;
    gnt_idx              = rr_winner(req_ext, ptr, NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = vld && (gnt_idx == RR_IDX_W'(i));
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between NUM_REQ requesters with a single-clock
// access sequencer; every pad and handshake output is a flop.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_be,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_dout,
  output logic                            sram_doe,
  input  logic [DATA_WIDTH-1:0]           sram_din,
  output logic                            sram_ce_n,
  output logic                            sram_oe_n,
  output logic                            sram_we_n,
  output logic [DATA_WIDTH/8-1:0]         sram_be_n
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = 3;

  SramState_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [RR_IDX_W-1:0] rr_ptr;
  logic [RR_IDX_W-1:0] owner;
  logic                owner_we;
  logic                gnt_pend;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [RR_IDX_W-1:0]   arb_idx;
  logic                  arb_vld;
  logic                  read_done;
  logic                  grant_ok;
  logic [RR_IDX_W-1:0]   next_ptr;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]       sel_be;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  // Arbitration happens on the edge that lands in IDLE, so the ack is visible
  // during the IDLE cycle, which also serves as address setup for the access.
  always_comb begin
    read_done = (state == READ) && (cnt == CNT_W'(READ_CYCLES - 1));
    grant_ok  = arb_vld && (((state == IDLE) && !gnt_pend) || read_done ||
                            (state == TURN));
    next_ptr  = (arb_idx == RR_IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == RR_IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be    = req_be[i*BE_W +: BE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_we  <= 1'b0;
      gnt_pend  <= 1'b0;
      ack       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_doe  <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
    end else begin
      ack    <= '0;
      rvalid <= '0;
      case (state)
        IDLE: begin
          if (gnt_pend) begin
            gnt_pend  <= 1'b0;
            cnt       <= '0;
            sram_ce_n <= 1'b0;
            if (owner_we) begin
              sram_we_n <= 1'b0;
              sram_doe  <= 1'b1;
              state     <= WRITE;
            end else begin
              sram_oe_n <= 1'b0;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (read_done) begin
            rdata         <= sram_din;
            rvalid[owner] <= 1'b1;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (cnt == CNT_W'(WRITE_CYCLES - 1)) begin
            sram_we_n <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          sram_doe  <= 1'b0;
          sram_ce_n <= 1'b1;
          state     <= TURN;
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Reads drive all byte lanes so the full word comes back.
      if (grant_ok) begin
        ack       <= arb_gnt;
        owner     <= arb_idx;
        owner_we  <= sel_we;
        gnt_pend  <= 1'b1;
        rr_ptr    <= next_ptr;
        sram_addr <= sel_addr;
        sram_dout <= sel_wdata;
        sram_be_n <= sel_we ? ~sel_be : '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 16-word behavioural SRAM keyed on the
// low address nibble.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int NR = 3;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*BW-1:0]  req_be;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_dout;
  logic              sram_doe;
  logic [DW-1:0]     sram_din;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [BW-1:0]     sram_be_n;

  logic [DW-1:0]     mem [16];
  int                n_cmp;
  int                n_fail;

  sram_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_CYCLES(2), .WRITE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : '0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < BW; b++) begin
        if (!sram_be_n[b]) mem[sram_addr[3:0]][b*8 +: 8] = sram_dout[b*8 +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ((!sram_oe_n && !sram_we_n) || (sram_doe && !sram_oe_n) ||
          ($countones(ack) > 1) || ($countones(rvalid) > 1)) begin
        n_fail++;
        $display("FAIL invariant: oe_n=%b we_n=%b doe=%b ack=%b rvalid=%b required legal combination",
                 sram_oe_n, sram_we_n, sram_doe, ack, rvalid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_be[i*BW +: BW] = be;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (ack !== 3'b000 || rvalid !== 3'b000) begin n_fail++;
      $display("FAIL reset_hs: ack=%b rvalid=%b want 000/000", ack, rvalid); end
    n_cmp++; if (rdata !== 32'h0 || sram_addr !== 20'h0 || sram_dout !== 32'h0) begin n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h dout=%h want zeros", rdata, sram_addr, sram_dout); end
    n_cmp++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_doe} !== 4'b1110) begin n_fail++;
      $display("FAIL reset_ctl: ce/oe/we/doe=%b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_doe}); end
    n_cmp++; if (sram_be_n !== 4'hF) begin n_fail++;
      $display("FAIL reset_be: be_n=%b want 1111", sram_be_n); end
    n_cmp++; if (dut.state !== IDLE || dut.rr_ptr !== 2'd0) begin n_fail++;
      $display("FAIL reset_fsm: state=%0d rr_ptr=%0d want 0/0", dut.state, dut.rr_ptr); end
  endtask

  task automatic test_single_read;
    mem[0] = 32'hDEADBEEF;
    set_req(1, 1'b0, 20'h00010, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++; if (ack !== 3'b010 || sram_ce_n !== 1'b1) begin n_fail++;
      $display("FAIL rd_ack: ack=%b ce_n=%b want 010/1", ack, sram_ce_n); end
    req[1] = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      n_cmp++; if ({sram_ce_n, sram_oe_n} !== 2'b00 || ack !== 3'b000 || rvalid !== 3'b000) begin n_fail++;
        $display("FAIL rd_strobe_t%0d: ce/oe=%b ack=%b rvalid=%b want 00/000/000", t, {sram_ce_n, sram_oe_n}, ack, rvalid); end
    end
    n_cmp++; if (sram_addr !== 20'h00010 || sram_be_n !== 4'h0) begin n_fail++;
      $display("FAIL rd_pads: addr=%h be_n=%b want 00010/0000", sram_addr, sram_be_n); end
    @(negedge clk);
    n_cmp++; if (rvalid !== 3'b010 || rdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL rd_data: rvalid=%b rdata=%h want 010/deadbeef", rvalid, rdata); end
    n_cmp++; if ({sram_ce_n, sram_oe_n} !== 2'b11) begin n_fail++;
      $display("FAIL rd_release: ce/oe=%b want 11", {sram_ce_n, sram_oe_n}); end
    @(negedge clk);
    n_cmp++; if (rvalid !== 3'b000) begin n_fail++;
      $display("FAIL rd_pulse: rvalid=%b want 000", rvalid); end
  endtask

  task automatic test_single_write;
    mem[15] = 32'hAAAAAAAA;
    set_req(2, 1'b1, 20'hFFFFF, 32'h12345678, 4'b0011);
    @(negedge clk);
    n_cmp++; if (ack !== 3'b100 || sram_we_n !== 1'b1 || sram_doe !== 1'b0) begin n_fail++;
      $display("FAIL wr_ack: ack=%b we_n=%b doe=%b want 100/1/0", ack, sram_we_n, sram_doe); end
    req[2] = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      n_cmp++; if ({sram_ce_n, sram_we_n, sram_oe_n, sram_doe} !== 4'b0011 || sram_be_n !== 4'b1100) begin n_fail++;
        $display("FAIL wr_strobe_t%0d: ce/we/oe/doe=%b be_n=%b want 0011/1100", t,
                 {sram_ce_n, sram_we_n, sram_oe_n, sram_doe}, sram_be_n); end
    end
    n_cmp++; if (sram_addr !== 20'hFFFFF || sram_dout !== 32'h12345678) begin n_fail++;
      $display("FAIL wr_pads: addr=%h dout=%h want fffff/12345678", sram_addr, sram_dout); end
    @(negedge clk);
    n_cmp++; if ({sram_ce_n, sram_we_n, sram_doe} !== 3'b011 || sram_dout !== 32'h12345678) begin n_fail++;
      $display("FAIL wr_hold: ce/we/doe=%b dout=%h want 011/12345678", {sram_ce_n, sram_we_n, sram_doe}, sram_dout); end
    @(negedge clk);
    n_cmp++; if ({sram_ce_n, sram_doe} !== 2'b10) begin n_fail++;
      $display("FAIL wr_turn: ce/doe=%b want 10", {sram_ce_n, sram_doe}); end
    @(negedge clk);
    n_cmp++; if (mem[15] !== 32'hAAAA5678) begin n_fail++;
      $display("FAIL wr_mem: mem=%h want aaaa5678", mem[15]); end
  endtask

  task automatic test_all_three;
    logic [2:0]  exp_ack [13];
    logic [2:0]  exp_rv  [13];
    logic [31:0] exp_rd  [13];
    mem[1] = 32'h11111111; mem[2] = 32'h22222222; mem[3] = 32'h33333333;
    for (int t = 0; t < 13; t++) begin exp_ack[t] = 3'b000; exp_rv[t] = 3'b000; exp_rd[t] = 32'h0; end
    exp_ack[0] = 3'b001; exp_ack[3] = 3'b010; exp_ack[6] = 3'b100; exp_ack[9] = 3'b001;
    exp_rv[3] = 3'b001;  exp_rv[6] = 3'b010;  exp_rv[9] = 3'b100;  exp_rv[12] = 3'b001;
    exp_rd[3] = 32'h11111111; exp_rd[6] = 32'h22222222; exp_rd[9] = 32'h33333333; exp_rd[12] = 32'h11111111;
    set_req(0, 1'b0, 20'h1, 32'h0, 4'h0);
    set_req(1, 1'b0, 20'h2, 32'h0, 4'h0);
    set_req(2, 1'b0, 20'h3, 32'h0, 4'h0);
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      n_cmp++; if (ack !== exp_ack[t] || rvalid !== exp_rv[t]) begin n_fail++;
        $display("FAIL rr_t%0d: ack=%b rvalid=%b want %b/%b", t, ack, rvalid, exp_ack[t], exp_rv[t]); end
      if (exp_rv[t] != 3'b000) begin
        n_cmp++; if (rdata !== exp_rd[t]) begin n_fail++;
          $display("FAIL rr_data_t%0d: rdata=%h want %h", t, rdata, exp_rd[t]); end
      end
      if (t == 3) req[1] = 1'b0;
      if (t == 6) req[2] = 1'b0;
      if (t == 9) req[0] = 1'b0;
    end
  endtask

  task automatic test_write_then_read;
    mem[5] = 32'h0;
    set_req(0, 1'b1, 20'h5, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    n_cmp++; if (ack !== 3'b001) begin n_fail++;
      $display("FAIL wtr_wack: ack=%b want 001", ack); end
    req[0] = 1'b0;
    set_req(1, 1'b0, 20'h5, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    n_cmp++; if ({sram_doe, sram_ce_n, sram_oe_n} !== 3'b011 || ack !== 3'b000) begin n_fail++;
      $display("FAIL wtr_turn: doe/ce/oe=%b ack=%b want 011/000", {sram_doe, sram_ce_n, sram_oe_n}, ack); end
    @(negedge clk);
    n_cmp++; if (ack !== 3'b010 || sram_oe_n !== 1'b1 || sram_doe !== 1'b0) begin n_fail++;
      $display("FAIL wtr_rack: ack=%b oe_n=%b doe=%b want 010/1/0", ack, sram_oe_n, sram_doe); end
    req[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (sram_oe_n !== 1'b0) begin n_fail++;
      $display("FAIL wtr_oe: oe_n=%b want 0", sram_oe_n); end
    repeat (2) @(negedge clk);
    n_cmp++; if (rvalid !== 3'b010 || rdata !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL wtr_data: rvalid=%b rdata=%h want 010/cafef00d", rvalid, rdata); end
  endtask

  task automatic test_starvation;
    int  delay;
    int  grants;
    bit  got2;
    delay  = int'($urandom_range(1, 6));
    grants = 0;
    got2   = 1'b0;
    set_req(0, 1'b0, 20'h6, 32'h0, 4'h0);
    repeat (delay) @(negedge clk);
    set_req(2, 1'b0, 20'h3, 32'h0, 4'h0);
    for (int c = 0; c < 60 && !got2; c++) begin
      @(negedge clk);
      if (ack != 3'b000) grants++;
      if (ack[2]) begin got2 = 1'b1; req[2] = 1'b0; end
    end
    req[0] = 1'b0;
    n_cmp++; if (got2 !== 1'b1) begin n_fail++;
      $display("FAIL starve_grant: req2 granted=%0d want 1", got2); end
    n_cmp++; if (grants > 3) begin n_fail++;
      $display("FAIL starve_bound: grants until req2=%0d want <=3", grants); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    set_req(1, 1'b0, 20'h7, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++; if (ack !== 3'b010) begin n_fail++;
      $display("FAIL rst_ack: ack=%b want 010", ack); end
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({sram_ce_n, sram_oe_n} !== 2'b00) begin n_fail++;
      $display("FAIL rst_pre: ce/oe=%b want 00", {sram_ce_n, sram_oe_n}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({sram_ce_n, sram_oe_n} !== 2'b11 || rvalid !== 3'b000 || rdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_async: ce/oe=%b rvalid=%b rdata=%h want 11/000/0", {sram_ce_n, sram_oe_n}, rvalid, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      n_cmp++; if (rvalid !== 3'b000 || sram_ce_n !== 1'b1) begin n_fail++;
        $display("FAIL rst_quiet_t%0d: rvalid=%b ce_n=%b want 000/1", t, rvalid, sram_ce_n); end
    end
    n_cmp++; if (dut.state !== IDLE || dut.rr_ptr !== 2'd0) begin n_fail++;
      $display("FAIL rst_fsm: state=%0d rr_ptr=%0d want 0/0", dut.state, dut.rr_ptr); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_all_three();
    test_write_then_read();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
